// File: rtl/dma64_pkg.sv
// Shared constants and engine state encoding for the 64-bit DMA memory responder.
package dma64_pkg;

  localparam logic [2:0] DMA_SIZE_64 = 3'b011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } eng_state_e;

  // A request is flagged if it is not 64-bit or runs past the end of memory.
  function automatic logic req_bad(input logic [2:0]  size,
                                   input logic [31:0] idx,
                                   input logic [31:0] len,
                                   input logic [32:0] words);
    return (size != DMA_SIZE_64) || (({1'b0, idx} + {1'b0, len}) > words);
  endfunction

endpackage

// File: rtl/dma64_mem_bank.sv
// Dual-port synchronous RAM: port A reads (1-cycle latency), port B writes.
// A same-cycle write to the word being read is forwarded (write-first).
module dma64_mem_bank #(
  parameter  int WORDS = 65536,
  localparam int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] i_addr_a,
  output logic [63:0]   o_rdata_a,
  input  logic          i_we_b,
  input  logic [AW-1:0] i_addr_b,
  input  logic [63:0]   i_wdata_b
);

  logic [63:0] r_mem [WORDS];
  logic [63:0] r_q_a;

  always_ff @(posedge clk)
    if (i_we_b) r_mem[i_addr_b] <= i_wdata_b;

  always_ff @(posedge clk or negedge rst)
    if (!rst)                                r_q_a <= '0;
    else if (i_we_b && i_addr_b == i_addr_a) r_q_a <= i_wdata_b;
    else                                     r_q_a <= r_mem[i_addr_a];

  assign o_rdata_a = r_q_a;

endmodule

// File: rtl/dma64_mem_responder.sv
// Memory-backed DMA target: independent read/write engines over a shared
// dual-port RAM, with host access while both engines are idle.
module dma64_mem_responder
  import dma64_pkg::*;
#(
  parameter  int MEM_WORDS      = 65536,
  parameter  int RD_LATENCY_GAP = 0,
  localparam int AW             = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dma_read_ctrl_valid,
  output logic          dma_read_ctrl_ready,
  input  logic [31:0]   dma_read_ctrl_data_index,
  input  logic [31:0]   dma_read_ctrl_data_length,
  input  logic [2:0]    dma_read_ctrl_data_size,
  input  logic [5:0]    dma_read_ctrl_data_user,
  output logic          dma_read_chnl_valid,
  input  logic          dma_read_chnl_ready,
  output logic [63:0]   dma_read_chnl_data,
  input  logic          dma_write_ctrl_valid,
  output logic          dma_write_ctrl_ready,
  input  logic [31:0]   dma_write_ctrl_data_index,
  input  logic [31:0]   dma_write_ctrl_data_length,
  input  logic [2:0]    dma_write_ctrl_data_size,
  input  logic [5:0]    dma_write_ctrl_data_user,
  input  logic          dma_write_chnl_valid,
  output logic          dma_write_chnl_ready,
  input  logic [63:0]   dma_write_chnl_data,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [63:0]   host_wdata,
  output logic [63:0]   host_rdata,
  output logic          busy,
  output logic          err,
  output logic          rd_done,
  output logic          wr_done
);

  eng_state_e       r_rd_state, r_wr_state;
  logic [AW-1:0]    r_rd_addr, r_wr_addr;
  logic [31:0]      r_rd_len, r_rd_issued, r_rd_sent, r_rd_gap;
  logic [31:0]      r_wr_len, r_wr_cnt;
  logic             r_rd_pend;
  logic [1:0][63:0] r_fifo;
  logic             r_fifo_wp, r_fifo_rp;
  logic [1:0]       r_fifo_cnt;
  logic             r_err;

  logic          w_rd_hs, w_wr_hs, w_pop, w_rd_issue, w_rd_last;
  logic          w_wr_beat, w_wr_last, w_host_we;
  logic [2:0]    w_occ;
  logic [63:0]   w_q_a;
  logic [AW-1:0] w_addr_a, w_addr_b;
  logic          w_we_b;
  logic [63:0]   w_wdata_b;
  logic          w_unused_user;

  assign w_unused_user = ^{dma_read_ctrl_data_user, dma_write_ctrl_data_user};

  assign busy                 = (r_rd_state != ST_IDLE) || (r_wr_state != ST_IDLE);
  assign err                  = r_err;
  assign dma_read_ctrl_ready  = (r_rd_state == ST_IDLE);
  assign dma_write_ctrl_ready = (r_wr_state == ST_IDLE);
  assign w_rd_hs              = dma_read_ctrl_valid && dma_read_ctrl_ready;
  assign w_wr_hs              = dma_write_ctrl_valid && dma_write_ctrl_ready;

  // Read side: issue a RAM read only when the beat is guaranteed a FIFO slot,
  // counting the one already in flight and any pop happening this cycle.
  assign dma_read_chnl_valid = (r_fifo_cnt != 2'd0);
  assign dma_read_chnl_data  = r_fifo[r_fifo_rp];
  assign w_pop               = dma_read_chnl_valid && dma_read_chnl_ready;
  assign w_occ               = {1'b0, r_fifo_cnt} + {2'b0, r_rd_pend};
  assign w_rd_issue          = (r_rd_state == ST_XFER) && (r_rd_issued != r_rd_len) &&
                               (r_rd_gap == '0) && ((w_occ < 3'd2) || (w_occ == 3'd2 && w_pop));
  assign w_rd_last           = (r_rd_state == ST_XFER) &&
                               ((r_rd_len == '0) || (w_pop && r_rd_sent == r_rd_len - 32'd1));
  assign rd_done             = w_rd_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_state  <= ST_IDLE;
      r_rd_addr   <= '0;
      r_rd_len    <= '0;
      r_rd_issued <= '0;
      r_rd_sent   <= '0;
      r_rd_gap    <= '0;
      r_rd_pend   <= 1'b0;
    end else begin
      r_rd_pend <= w_rd_issue;
      if (w_rd_issue) begin
        r_rd_addr   <= r_rd_addr + 1'b1;
        r_rd_issued <= r_rd_issued + 32'd1;
        r_rd_gap    <= 32'(RD_LATENCY_GAP);
      end else if (r_rd_gap != '0) begin
        r_rd_gap <= r_rd_gap - 32'd1;
      end
      if (w_pop) r_rd_sent <= r_rd_sent + 32'd1;
      case (r_rd_state)
        ST_IDLE: if (w_rd_hs) begin
          r_rd_addr   <= dma_read_ctrl_data_index[AW-1:0];
          r_rd_len    <= dma_read_ctrl_data_length;
          r_rd_issued <= '0;
          r_rd_sent   <= '0;
          r_rd_gap    <= '0;
          r_rd_state  <= ST_XFER;
        end
        ST_XFER: if (w_rd_last) r_rd_state <= ST_IDLE;
        default: r_rd_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fifo     <= '0;
      r_fifo_wp  <= 1'b0;
      r_fifo_rp  <= 1'b0;
      r_fifo_cnt <= '0;
    end else begin
      if (r_rd_pend) begin
        r_fifo[r_fifo_wp] <= w_q_a;
        r_fifo_wp         <= ~r_fifo_wp;
      end
      if (w_pop) r_fifo_rp <= ~r_fifo_rp;
      r_fifo_cnt <= r_fifo_cnt + {1'b0, r_rd_pend} - {1'b0, w_pop};
    end
  end

  // Write side: beats go straight to RAM port B in the handshake cycle.
  assign dma_write_chnl_ready = (r_wr_state == ST_XFER) && (r_wr_len != '0);
  assign w_wr_beat            = dma_write_chnl_valid && dma_write_chnl_ready;
  assign w_wr_last            = (r_wr_state == ST_XFER) &&
                                ((r_wr_len == '0) || (w_wr_beat && r_wr_cnt == r_wr_len - 32'd1));
  assign wr_done              = w_wr_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_state <= ST_IDLE;
      r_wr_addr  <= '0;
      r_wr_len   <= '0;
      r_wr_cnt   <= '0;
    end else begin
      case (r_wr_state)
        ST_IDLE: if (w_wr_hs) begin
          r_wr_addr  <= dma_write_ctrl_data_index[AW-1:0];
          r_wr_len   <= dma_write_ctrl_data_length;
          r_wr_cnt   <= '0;
          r_wr_state <= ST_XFER;
        end
        ST_XFER: begin
          if (w_wr_beat) begin
            r_wr_addr <= r_wr_addr + 1'b1;
            r_wr_cnt  <= r_wr_cnt + 32'd1;
          end
          if (w_wr_last) r_wr_state <= ST_IDLE;
        end
        default: r_wr_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_err <= 1'b0;
    else if ((w_rd_hs && req_bad(dma_read_ctrl_data_size, dma_read_ctrl_data_index,
                                 dma_read_ctrl_data_length, 33'(MEM_WORDS))) ||
             (w_wr_hs && req_bad(dma_write_ctrl_data_size, dma_write_ctrl_data_index,
                                 dma_write_ctrl_data_length, 33'(MEM_WORDS))) ||
             (host_we && busy))
      r_err <= 1'b1;
  end

  assign w_host_we  = host_we && !busy;
  assign w_addr_a   = w_rd_issue ? r_rd_addr : host_addr;
  assign w_we_b     = w_wr_beat || w_host_we;
  assign w_addr_b   = w_wr_beat ? r_wr_addr : host_addr;
  assign w_wdata_b  = w_wr_beat ? dma_write_chnl_data : host_wdata;
  assign host_rdata = w_q_a;

  dma64_mem_bank #(.WORDS(MEM_WORDS)) u_bank (
    .clk       (clk),
    .rst       (rst),
    .i_addr_a  (w_addr_a),
    .o_rdata_a (w_q_a),
    .i_we_b    (w_we_b),
    .i_addr_b  (w_addr_b),
    .i_wdata_b (w_wdata_b)
  );

endmodule

// File: tb/tb_dma64_mem_responder.sv
// Directed bench: host preload, streaming/throttled reads, writes, wrap,
// zero-length, bad size, mid-transfer reset and host access while busy.
module tb_dma64_mem_responder;
  localparam int MW = 64;
  localparam int AW = $clog2(MW);

  logic          clk, rst;
  logic          rcv, rcr, rchv, rchr, wcv, wcr, wchv, wchr;
  logic [31:0]   rci, rcl, wci, wcl;
  logic [2:0]    rcs, wcs;
  logic [63:0]   rchd, wchd, hwd, hrd;
  logic          hwe, busy, err, rd_done, wr_done;
  logic [AW-1:0] ha;

  int n_chk = 0, n_err = 0;
  int k, p, wd_cnt;
  logic started, hold;
  logic [63:0] exp_d [8];

  dma64_mem_responder #(.MEM_WORDS(MW), .RD_LATENCY_GAP(0)) dut (
    .clk(clk), .rst(rst),
    .dma_read_ctrl_valid(rcv), .dma_read_ctrl_ready(rcr),
    .dma_read_ctrl_data_index(rci), .dma_read_ctrl_data_length(rcl),
    .dma_read_ctrl_data_size(rcs), .dma_read_ctrl_data_user(6'h15),
    .dma_read_chnl_valid(rchv), .dma_read_chnl_ready(rchr), .dma_read_chnl_data(rchd),
    .dma_write_ctrl_valid(wcv), .dma_write_ctrl_ready(wcr),
    .dma_write_ctrl_data_index(wci), .dma_write_ctrl_data_length(wcl),
    .dma_write_ctrl_data_size(wcs), .dma_write_ctrl_data_user(6'h2a),
    .dma_write_chnl_valid(wchv), .dma_write_chnl_ready(wchr), .dma_write_chnl_data(wchd),
    .host_we(hwe), .host_addr(ha), .host_wdata(hwd), .host_rdata(hrd),
    .busy(busy), .err(err), .rd_done(rd_done), .wr_done(wr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic hw(input logic [AW-1:0] a, input logic [63:0] d);
    @(negedge clk); hwe = 1'b1; ha = a; hwd = d;
    @(posedge clk); #1 hwe = 1'b0;
  endtask

  task automatic hr(input string tag, input logic [AW-1:0] a, input logic [63:0] e);
    @(negedge clk); ha = a;
    @(negedge clk); #1 chk(tag, hrd, e);
  endtask

  // Straight read with chnl_ready held high; expects values from exp_d.
  task automatic rd_run(input string tag, input logic [31:0] idx, input int len);
    @(negedge clk); rcv = 1'b1; rci = idx; rcl = 32'(len); rcs = 3'b011; rchr = 1'b1;
    #1 chk({tag, "_cready"}, rcr, 1'b1);
    @(negedge clk); rcv = 1'b0;
    #1 chk({tag, "_lat1"}, rchv, 1'b0); chk({tag, "_busy"}, busy, 1'b1);
    @(negedge clk); #1 chk({tag, "_lat2"}, rchv, 1'b0);
    for (int i = 0; i < len; i++) begin
      @(negedge clk); #1;
      chk({tag, "_vld"}, rchv, 1'b1);
      chk({tag, "_data"}, rchd, exp_d[i]);
      chk({tag, "_done"}, rd_done, i == len - 1);
    end
    @(negedge clk); #1;
    chk({tag, "_end_vld"}, rchv, 1'b0);
    chk({tag, "_end_done"}, rd_done, 1'b0);
    chk({tag, "_end_cready"}, rcr, 1'b1);
  endtask

  initial begin
    rst = 1'b0; rcv = 0; rci = 0; rcl = 0; rcs = 3'b011; rchr = 0;
    wcv = 0; wci = 0; wcl = 0; wcs = 3'b011; wchv = 0; wchd = 0;
    hwe = 0; ha = 0; hwd = 0;
    #2;
    chk("rst_rcready", rcr, 1'b1); chk("rst_wcready", wcr, 1'b1);
    chk("rst_rvalid", rchv, 1'b0); chk("rst_wchready", wchr, 1'b0);
    chk("rst_rdata", rchd, 64'h0); chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0); chk("rst_rd_done", rd_done, 1'b0);
    chk("rst_wr_done", wr_done, 1'b0); chk("rst_hrdata", hrd, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) hw(AW'(i), 64'h100 + 64'(i));
    hw(AW'(62), 64'hE62); hw(AW'(63), 64'hE63); hw(AW'(30), 64'h30);
    hr("host_rd3", AW'(3), 64'h103);

    for (int i = 0; i < 8; i++) exp_d[i] = 64'h100 + 64'(i);
    rd_run("rd8", 32'd0, 8);

    // Throttled read: ready toggles 1/0 from the first valid cycle.
    @(negedge clk); rcv = 1'b1; rci = 0; rcl = 8; rchr = 1'b0;
    @(negedge clk); rcv = 1'b0;
    started = 0; hold = 0; p = 0; k = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      @(negedge clk); #1;
      if (hold) chk("tog_hold_vld", rchv, 1'b1);
      if (rchv && !started) started = 1'b1;
      rchr = started && (p % 2 == 0);
      #1;
      if (rchv) begin
        chk("tog_data", rchd, 64'h100 + 64'(k));
        if (rchr) begin chk("tog_done", rd_done, k == 7); k++; end
      end
      hold = rchv && !rchr;
      if (started) p++;
    end
    chk("tog_beats", 64'(k), 64'd8);
    chk("tog_span", 64'(p), 64'd15);
    @(negedge clk); #1 chk("tog_end_vld", rchv, 1'b0); chk("tog_cready", rcr, 1'b1);

    // Write 4 beats at 16.
    wd_cnt = 0;
    @(negedge clk); wcv = 1'b1; wci = 16; wcl = 4; wcs = 3'b011;
    #1 chk("wr_cready", wcr, 1'b1); chk("wr_chready0", wchr, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); wcv = 1'b0; wchv = 1'b1; wchd = 64'hA0 + 64'(i);
      #1 chk("wr_chready", wchr, 1'b1); chk("wr_done_beat", wr_done, i == 3);
      if (wr_done) wd_cnt++;
    end
    @(negedge clk); wchv = 1'b0;
    #1 chk("wr_chready_end", wchr, 1'b0); chk("wr_done_end", wr_done, 1'b0);
    chk("wr_cready_end", wcr, 1'b1);
    if (wr_done) wd_cnt++;
    chk("wr_done_count", 64'(wd_cnt), 64'd1);
    for (int i = 0; i < 4; i++) hr("wr_readback", AW'(16 + i), 64'hA0 + 64'(i));
    chk("wr_err", err, 1'b0);

    exp_d[0] = 64'hE62; exp_d[1] = 64'hE63; exp_d[2] = 64'h100; exp_d[3] = 64'h101;
    rd_run("wrap", 32'(MW - 2), 4);
    chk("wrap_err", err, 1'b1);

    // Reset clears err but keeps memory.
    @(negedge clk); rst = 1'b0;
    #1 chk("rst2_err", err, 1'b0); chk("rst2_hrdata", hrd, 64'h0);
    @(negedge clk); rst = 1'b1;
    hr("mem_kept", AW'(0), 64'h100);

    @(negedge clk); rcv = 1'b1; rci = 5; rcl = 0; rcs = 3'b011; rchr = 1'b1;
    #1 chk("len0_done_hs", rd_done, 1'b0);
    @(negedge clk); rcv = 1'b0;
    #1 chk("len0_done", rd_done, 1'b1); chk("len0_vld", rchv, 1'b0);
    @(negedge clk); #1 chk("len0_done_end", rd_done, 1'b0); chk("len0_vld_end", rchv, 1'b0);
    chk("len0_busy", busy, 1'b0); chk("len0_err", err, 1'b0);

    @(negedge clk); wcv = 1'b1; wci = 40; wcl = 1; wcs = 3'b010;
    @(negedge clk); wcv = 1'b0; wchv = 1'b1; wchd = 64'h55;
    #1 chk("sz_chready", wchr, 1'b1); chk("sz_done", wr_done, 1'b1);
    @(negedge clk); wchv = 1'b0;
    #1 chk("sz_chready_end", wchr, 1'b0); chk("sz_err", err, 1'b1);
    hr("sz_readback", AW'(40), 64'h55);

    // Reset after 3 of 8 beats.
    @(negedge clk); rcv = 1'b1; rci = 0; rcl = 8; rcs = 3'b011; rchr = 1'b1;
    @(negedge clk); rcv = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1 chk("mid_data", rchd, 64'h100 + 64'(i)); chk("mid_done", rd_done, 1'b0);
    end
    @(negedge clk); rst = 1'b0;
    #1 chk("mid_rst_vld", rchv, 1'b0); chk("mid_rst_done", rd_done, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    @(negedge clk); #1 chk("mid_rst_done2", rd_done, 1'b0);
    rst = 1'b1;
    exp_d[0] = 64'h104; exp_d[1] = 64'h105;
    rd_run("after_rst", 32'd4, 2);
    chk("after_rst_err", err, 1'b0);

    // Host write while busy is dropped and flagged.
    @(negedge clk); rcv = 1'b1; rci = 0; rcl = 2; rchr = 1'b0;
    @(negedge clk); rcv = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("hb_busy", busy, 1'b1); chk("hb_vld", rchv, 1'b1);
    hw(AW'(30), 64'hBAD);
    chk("hb_err", err, 1'b1);
    @(negedge clk); rchr = 1'b1;
    #1 chk("hb_d0", rchd, 64'h100); chk("hb_done0", rd_done, 1'b0);
    @(negedge clk); #1 chk("hb_d1", rchd, 64'h101); chk("hb_done1", rd_done, 1'b1);
    @(negedge clk); #1 chk("hb_idle", busy, 1'b0);
    hr("hb_mem", AW'(30), 64'h30);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/dma64_mem_responder.md
DMA64_MEM_RESPONDER -- requirements
Module: dma64_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 65536, meaning depth in 64-bit words (power of 2).
REQ-002 SHALL have parameter RD_LATENCY_GAP, default 0, meaning idle cycles inserted between read beats for throttling.
REQ-003 SHALL have ports `clk` (in, 1, sole clock) and `rst` (in, 1, asynchronous, active-low reset).
REQ-004 SHALL have DMA read control ports: dma_read_ctrl_valid in 1; dma_read_ctrl_ready out 1; dma_read_ctrl_data_index in 32 (word index); dma_read_ctrl_data_length in 32 (beats); dma_read_ctrl_data_size in 3; dma_read_ctrl_data_user in 6.
REQ-005 SHALL have DMA read channel ports: dma_read_chnl_valid out 1; dma_read_chnl_ready in 1; dma_read_chnl_data out 64.
REQ-006 SHALL have DMA write control ports: dma_write_ctrl_valid in 1; dma_write_ctrl_ready out 1; dma_write_ctrl_data_index in 32; dma_write_ctrl_data_length in 32; dma_write_ctrl_data_size in 3; dma_write_ctrl_data_user in 6.
REQ-007 SHALL have DMA write channel ports: dma_write_chnl_valid in 1; dma_write_chnl_ready out 1; dma_write_chnl_data in 64.
REQ-008 SHALL have host ports: host_we in 1; host_addr in $clog2(MEM_WORDS); host_wdata in 64; host_rdata out 64 (1-cycle read latency); busy out 1; err out 1 (sticky); rd_done out 1 (pulse); wr_done out 1 (pulse).

Function
REQ-009 SHALL run independent read and write engines, each with states IDLE -> XFER -> IDLE.
REQ-010 SHALL hold dma_read_ctrl_ready high only in read IDLE; on the valid&&ready cycle it SHALL latch index and length and go to XFER.
REQ-011 SHALL return each read beat mem[(index+k) mod MEM_WORDS] for k = 0..length-1, in order.
REQ-012 SHALL buffer read data in a 2-entry output FIFO fed by the 1-cycle synchronous RAM, so that 1 beat/cycle is sustained when chnl_ready stays high and RD_LATENCY_GAP = 0.
REQ-013 SHALL hold dma_read_chnl_valid and its data stable while dma_read_chnl_ready is low, with no beat lost or duplicated.
REQ-014 SHALL finish the read on the cycle the last beat handshakes: pulse rd_done for 1 cycle and return to IDLE, with ctrl_ready high the next cycle.
REQ-015 SHALL hold dma_write_ctrl_ready high only in write IDLE; after the ctrl handshake it SHALL raise dma_write_chnl_ready on the next cycle.
REQ-016 SHALL write each chnl handshake beat to mem[(index+k) mod MEM_WORDS] in the same cycle; on the last beat it SHALL drop chnl_ready, pulse wr_done, and return to IDLE.
REQ-017 SHALL treat length 0 as accepted-and-complete: done pulse the cycle after the ctrl handshake, no beats.
REQ-018 SHALL set err when size != 3'b011 or index+length > MEM_WORDS; the transfer still proceeds as 64-bit with address wrap; err is cleared only by reset.
REQ-019 SHALL order a read and a write engine accessing the same word in the same cycle as write-first: the read returns the new data.
REQ-020 SHALL assert busy whenever either engine is not IDLE.
REQ-021 SHALL ignore host_we while busy and SHALL flag err when it does.
REQ-022 SHALL ignore the user fields.

Reset
REQ-023 SHALL, on rst low, asynchronously force both engines to IDLE and set: ctrl_ready outputs 1 when released; chnl_valid/chnl_ready 0; dma_read_chnl_data 0; FIFO empty; err, rd_done, wr_done, busy 0; host_rdata 0.
REQ-024 SHALL NOT reset memory contents.
REQ-025 SHALL, when reset is asserted mid-transfer, abandon the transfer with no done pulse.

Structure
REQ-026 SHALL take the DMA_SIZE_64 = 3'b011 constant and the engine state enum from a shared package, dma64_pkg.
REQ-027 SHALL instantiate one sub-module, dma64_mem_bank: a dual-port synchronous RAM (port A: read engine/host read; port B: write engine/host write).

Verification
REQ-028 Preload mem[0..7] = 0x100..0x107 via host; read ctrl index 0, length 8, chnl_ready high -> 8 beats 0x100..0x107 on consecutive cycles; rd_done on the 8th beat cycle.
REQ-029 Same read with chnl_ready toggled 1/0 each cycle -> same 8 values, each held while ready is low, 15 cycles of transfer.
REQ-030 Write index 16, length 4, data 0xA0..0xA3 -> host reads mem[16..19] = 0xA0..0xA3; wr_done pulses once; err = 0.
REQ-031 Read index MEM_WORDS-2, length 4 -> beats mem[MEM_WORDS-2], mem[MEM_WORDS-1], mem[0], mem[1]; err = 1.
REQ-032 Length 0 read, then size 3'b010 write of 1 beat -> rd_done with no beats; write completes; err = 1.
REQ-033 Assert rst after 3 of 8 read beats -> valid = 0 immediately, no rd_done; a new ctrl after reset is accepted normally.
